// File: rtl/uart_rx_stage.sv
// uart_rx_stage: 8N1 serial receiver with a one-entry valid/ready output buffer.
// Flags framing errors and overruns so the command stream can resynchronise.
module uart_rx_stage #(
    parameter int CLKS_PER_BIT = 87,
    parameter int HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       FRAME_ERR,
    output logic       OVERRUN
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic          sync1;
    logic          rxd_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          at_last;
    logic          deliver;
    logic          handshake;

    assign at_last   = (cnt == CNT_LAST);
    assign deliver   = (state == S_STOP) && at_last && rxd_s;
    assign handshake = RX_VALID && RX_READY;

    // Idle-high reset value keeps a reset from looking like a start bit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= RXD;
            rxd_s <= sync1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            FRAME_ERR <= 1'b0;
        end else begin
            FRAME_ERR <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        idx <= '0;
                        state <= rxd_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (at_last) begin
                        cnt   <= '0;
                        shreg <= {rxd_s, shreg[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (at_last) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            state <= S_IDLE;
                        end else begin
                            FRAME_ERR <= 1'b1;
                            state     <= S_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    // A held-low line (break) is reported once, then ignored.
                    if (rxd_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RX_DATA  <= '0;
            RX_VALID <= 1'b0;
            OVERRUN  <= 1'b0;
        end else begin
            OVERRUN <= 1'b0;
            if (deliver) begin
                if (!RX_VALID || RX_READY) begin
                    RX_DATA  <= shreg;
                    RX_VALID <= 1'b1;
                end else begin
                    OVERRUN <= 1'b1;
                end
            end else if (handshake) begin
                RX_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_stage.sv
// tb_uart_rx_stage: directed 8N1 frames at 8 clocks/bit against uart_rx_stage.
// Checks reset state, latency, glitch rejection, framing, overrun and reset abort.
module tb_uart_rx_stage;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       RXD = 1'b1;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY = 1'b0;
    logic       FRAME_ERR;
    logic       OVERRUN;

    int applied = 0;
    int errs = 0;

    int cyc = 0;
    int rises = 0;
    int highs = 0;
    int lows = 0;
    int fes = 0;
    int ovs = 0;
    int unstable = 0;
    int rise_cyc = 0;
    logic [7:0] rise_data = 8'h00;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [7:0] pd = 8'h00;

    int start_cyc;
    int b_rises, b_highs, b_lows, b_fes, b_ovs, b_unst;

    uart_rx_stage #(.CLKS_PER_BIT(8)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .RXD(RXD),
        .RX_DATA(RX_DATA),
        .RX_VALID(RX_VALID),
        .RX_READY(RX_READY),
        .FRAME_ERR(FRAME_ERR),
        .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc = cyc + 1;

    always @(negedge CLK) begin
        if (RX_VALID && !pv) begin
            rises = rises + 1;
            rise_data = RX_DATA;
            rise_cyc = cyc;
        end
        if (RX_VALID) highs = highs + 1;
        else lows = lows + 1;
        if (RX_VALID && pv && !pr && RX_DATA != pd) unstable = unstable + 1;
        if (FRAME_ERR) fes = fes + 1;
        if (OVERRUN) ovs = ovs + 1;
        pv = RX_VALID;
        pr = RX_READY;
        pd = RX_DATA;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        applied = applied + 1;
        assert (obs === exp) else begin
            errs = errs + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic snap();
        b_rises = rises;
        b_highs = highs;
        b_lows = lows;
        b_fes = fes;
        b_ovs = ovs;
        b_unst = unstable;
    endtask

    // Caller is aligned 1 time unit after a rising edge.
    task automatic send_frame(input logic [7:0] d, input logic stp,
                              input int rst_bit, input bit rdy_pulse);
        logic [9:0] bits;
        bits = {stp, d, 1'b0};
        start_cyc = cyc;
        for (int b = 0; b < 10; b++) begin
            RXD = bits[b];
            for (int k = 0; k < 8; k++) begin
                if (rst_bit >= 0 && b == rst_bit + 1 && k == 3) RESET = 1'b1;
                if (rdy_pulse && b == 9 && k == 6) RX_READY = 1'b1;
                @(posedge CLK);
                #1;
                if (RESET) begin
                    RESET = 1'b0;
                    RXD = 1'b1;
                    return;
                end
                if (rdy_pulse && b == 9 && k == 6) RX_READY = 1'b0;
            end
        end
    endtask

    initial begin
        tick(3);
        chk("rst_valid", 32'(RX_VALID), 32'd0);
        chk("rst_data", 32'(RX_DATA), 32'h00);
        chk("rst_ferr", 32'(FRAME_ERR), 32'd0);
        chk("rst_ovr", 32'(OVERRUN), 32'd0);
        RESET = 1'b0;
        tick(5);

        // 1: basic byte with downstream always ready
        RX_READY = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1, -1, 1'b0);
        tick(4);
        chk("t1_data", 32'(rise_data), 32'hA5);
        chk("t1_lat", 32'(rise_cyc - start_cyc >= 78 && rise_cyc - start_cyc <= 80), 32'd1);
        chk("t1_rises", 32'(rises - b_rises), 32'd1);
        chk("t1_width", 32'(highs - b_highs), 32'd1);
        chk("t1_ferr", 32'(fes - b_fes), 32'd0);
        chk("t1_ovr", 32'(ovs - b_ovs), 32'd0);

        // 2: short start glitch is rejected
        snap();
        RXD = 1'b0;
        tick(2);
        RXD = 1'b1;
        tick(20);
        chk("t2_glitch_valid", 32'(rises - b_rises), 32'd0);
        send_frame(8'h3C, 1'b1, -1, 1'b0);
        tick(4);
        chk("t2_rises", 32'(rises - b_rises), 32'd1);
        chk("t2_data", 32'(rise_data), 32'h3C);
        chk("t2_ferr", 32'(fes - b_fes), 32'd0);

        // 3: bad stop bit followed by a long break
        snap();
        send_frame(8'h55, 1'b0, -1, 1'b0);
        tick(160);
        chk("t3_ferr_once", 32'(fes - b_fes), 32'd1);
        chk("t3_no_valid", 32'(rises - b_rises), 32'd0);
        RXD = 1'b1;
        tick(20);
        send_frame(8'h81, 1'b1, -1, 1'b0);
        tick(4);
        chk("t3_ferr_total", 32'(fes - b_fes), 32'd1);
        chk("t3_rises", 32'(rises - b_rises), 32'd1);
        chk("t3_data", 32'(rise_data), 32'h81);

        // 4: overrun while the buffer is held
        RX_READY = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, -1, 1'b0);
        send_frame(8'h22, 1'b1, -1, 1'b0);
        tick(4);
        chk("t4_rises", 32'(rises - b_rises), 32'd1);
        chk("t4_valid", 32'(RX_VALID), 32'd1);
        chk("t4_data", 32'(RX_DATA), 32'h11);
        chk("t4_stable", 32'(unstable - b_unst), 32'd0);
        chk("t4_ovr", 32'(ovs - b_ovs), 32'd1);
        chk("t4_ferr", 32'(fes - b_fes), 32'd0);
        RX_READY = 1'b1;
        tick(1);
        chk("t4_drain", 32'(RX_VALID), 32'd0);
        RX_READY = 1'b0;
        tick(4);

        // 5: handshake lands exactly on the next delivery
        snap();
        send_frame(8'h00, 1'b1, -1, 1'b0);
        chk("t5_first", 32'(RX_DATA), 32'h00);
        chk("t5_first_valid", 32'(RX_VALID), 32'd1);
        b_lows = lows;
        send_frame(8'hFF, 1'b1, -1, 1'b1);
        tick(2);
        chk("t5_data", 32'(RX_DATA), 32'hFF);
        chk("t5_valid", 32'(RX_VALID), 32'd1);
        chk("t5_no_gap", 32'(lows - b_lows), 32'd0);
        chk("t5_ovr", 32'(ovs - b_ovs), 32'd0);
        chk("t5_stable", 32'(unstable - b_unst), 32'd0);
        RX_READY = 1'b1;
        tick(3);

        // 6: reset in the middle of data bit 4
        snap();
        send_frame(8'h96, 1'b1, 4, 1'b0);
        chk("t6_valid", 32'(RX_VALID), 32'd0);
        chk("t6_data", 32'(RX_DATA), 32'h00);
        chk("t6_ferr", 32'(FRAME_ERR), 32'd0);
        chk("t6_ovr", 32'(OVERRUN), 32'd0);
        tick(30);
        chk("t6_no_byte", 32'(rises - b_rises), 32'd0);
        send_frame(8'h5A, 1'b1, -1, 1'b0);
        tick(4);
        chk("t6_rises", 32'(rises - b_rises), 32'd1);
        chk("t6_rx", 32'(rise_data), 32'h5A);
        chk("t6_flags", 32'((fes - b_fes) + (ovs - b_ovs)), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end

endmodule

// File: doc/uart_rx_stage.md
Name: uart_rx_stage

Overview:
- Serial receive front end that sits directly upstream of NeuralChip's command/operand logic.
- Turns the raw asynchronous RXD pin into validated 8N1 bytes.
- Presents each byte through a one-entry valid/ready buffer.
- Flags framing errors and overruns so the downstream stage can resynchronise its command stream.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200); legal range >= 4.
- HALF_BIT, (CLKS_PER_BIT-1)/2, derived; start-bit validation point. Do not override.

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  synchronous, active-high reset
- RXD  input  1  raw asynchronous serial line, idle high
- RX_DATA  output  8  received byte, valid while RX_VALID=1
- RX_VALID  output  1  buffer holds an unconsumed byte
- RX_READY  input  1  downstream accepts RX_DATA when RX_VALID&&RX_READY
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low
- OVERRUN  output  1  one-cycle pulse: completed byte dropped because buffer full

Behaviour:
- Clocking and reset:
  - One clock (CLK); RESET is synchronous, active-high.
  - On RESET: state=IDLE, counters=0, shift register=0, both synchroniser flops=1, RX_DATA=0, RX_VALID=0, FRAME_ERR=0, OVERRUN=0.
  - RESET mid-frame aborts the frame silently: no error pulse, buffer cleared.
- Synchroniser: two flops on RXD produce rxd_s, 2-cycle latency. All FSM decisions use rxd_s only.
- Counter: bit counter width clog2(CLKS_PER_BIT); bit index 0..7.
- FSM states IDLE, START, DATA, STOP, WAIT_HIGH:
  - IDLE: rxd_s==0 -> START, counter=0.
  - START: counter increments each cycle. At counter==HALF_BIT:
    - rxd_s==0 -> DATA, counter=0, bit index=0.
    - rxd_s==1 -> IDLE (glitch rejected, no flag).
  - DATA: counter counts 0..CLKS_PER_BIT-1. At terminal count:
    - rxd_s is shifted in LSB-first (shift right, sample enters bit 7), bit index++, counter=0.
    - After the 8th sample -> STOP.
  - STOP: at counter==CLKS_PER_BIT-1, sample rxd_s:
    - 1: byte delivered to buffer (below), -> IDLE. Sampling at mid-stop-bit allows back-to-back frames.
    - 0: FRAME_ERR=1 for exactly one cycle, byte discarded, -> WAIT_HIGH.
  - WAIT_HIGH: stays until rxd_s==1, then -> IDLE. A line held low (break) produces exactly one FRAME_ERR.
- Output buffer (one entry):
  - Delivery with buffer empty, or in the same cycle as a handshake (RX_VALID&&RX_READY): RX_DATA<=byte, RX_VALID<=1 the next cycle. No OVERRUN.
  - Delivery with buffer full and no handshake that cycle: held byte kept unchanged, new byte dropped, OVERRUN=1 for one cycle.
  - Handshake without delivery: RX_VALID<=0. RX_DATA holds its last value.
  - RX_DATA is stable while RX_VALID=1 and RX_READY=0.
- Latency:
  - RX_VALID rises 9.5*CLKS_PER_BIT + 2..+4 cycles after the RXD falling edge at the pin (buffer empty).
  - FRAME_ERR/OVERRUN assert in the same cycle that RX_VALID would have risen.
- FRAME_ERR and OVERRUN cannot both pulse for the same frame.

Test Plan:
All tests use CLKS_PER_BIT=8 and drive bits exactly 8 cycles wide.
1. Send 0xA5 with RX_READY=1 -> RX_DATA=0xA5, RX_VALID high for one cycle, within 78..80 cycles of the start edge; FRAME_ERR=OVERRUN=0.
2. RXD low for 2 cycles, then high; then send 0x3C -> glitch yields no RX_VALID and no FRAME_ERR; 0x3C received correctly.
3. Send 0x55 with stop bit=0, then hold RXD low for 20 bit times, then release and send 0x81 -> exactly one FRAME_ERR pulse, no RX_VALID for 0x55, then 0x81 received.
4. RX_READY=0, send 0x11 then 0x22 -> RX_VALID=1, RX_DATA=0x11 throughout, one OVERRUN pulse at 0x22's stop sample. Raise RX_READY -> RX_VALID falls the next cycle.
5. Hold 0x00 unconsumed; assert RX_READY exactly in the delivery cycle of 0xFF (back-to-back frames) -> RX_DATA=0xFF, RX_VALID stays 1, no OVERRUN.
6. Assert RESET for one cycle during DATA bit 4 of 0x96 -> all outputs 0 and no flags. The next full frame 0x5A is received correctly.
